// File: rtl/sqr_add_seq_uns.sv
// Sequential square-and-add: rebuilds X = Q*Q + R from a root/remainder pair,
// one multiplier bit per cycle, with valid/ready on both sides.
module sqr_add_seq_uns #(
   parameter  int widthX = 8,
   localparam int widthQ = (widthX + 1) / 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [widthQ-1:0] Q_i,
   input  logic [widthQ:0]   R_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [widthX-1:0] X_o,
   output logic              ovf_o,
   output logic              inv_o
);

   localparam int AW = 2 * widthQ + 1;
   localparam int MW = 2 * widthQ;
   localparam int CW = $clog2(widthQ + 1);
   localparam logic [CW-1:0] LAST = CW'(widthQ - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            r_state, w_state_nx;
   logic [AW-1:0]     r_acc;
   logic [MW-1:0]     r_mreg;
   logic [widthQ-1:0] r_qreg;
   logic [CW-1:0]     r_cnt;
   logic              r_inv;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= IDLE;
      else         r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         IDLE:    if (in_valid_i)      w_state_nx = CALC;
         CALC:    if (r_cnt == LAST)   w_state_nx = DONE;
         DONE:    if (out_ready_i)     w_state_nx = IDLE;
         default:                      w_state_nx = IDLE;
      endcase
   end

   // Fixed widthQ iterations, even when qreg empties early, so latency never depends on data.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_acc  <= '0;
         r_mreg <= '0;
         r_qreg <= '0;
         r_cnt  <= '0;
         r_inv  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (in_valid_i) begin
               r_acc  <= AW'(R_i);
               r_mreg <= MW'(Q_i);
               r_qreg <= Q_i;
               r_cnt  <= '0;
               r_inv  <= (R_i > {Q_i, 1'b0});
            end
            CALC: begin
               if (r_qreg[0]) r_acc <= r_acc + AW'(r_mreg);
               r_qreg <= r_qreg >> 1;
               r_mreg <= r_mreg << 1;
               r_cnt  <= r_cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign in_ready_o  = (r_state == IDLE);
   assign out_valid_o = (r_state == DONE);
   assign X_o         = r_acc[widthX-1:0];
   assign ovf_o       = |r_acc[AW-1:widthX];
   assign inv_o       = r_inv;

   // A producer must hold its pair until it is taken.
   a_hold_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (in_valid_i && !in_ready_o) |=> in_valid_i);

endmodule

// File: tb/tb_sqr_add_seq_uns.sv
// Scoreboard bench: two lockstep units (widthX=8 and widthX=7) share one stimulus stream.
module tb_sqr_add_seq_uns;

   logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic [3:0] q = '0;
   logic [4:0] r = '0;
   logic       rdy8, v8, ovf8, inv8, rdy7, v7, ovf7, inv7;
   logic [7:0] x8;
   logic [6:0] x7;

   sqr_add_seq_uns #(.widthX(8)) u8 (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy8),
      .Q_i(q), .R_i(r), .out_valid_o(v8), .out_ready_i(out_ready),
      .X_o(x8), .ovf_o(ovf8), .inv_o(inv8));

   sqr_add_seq_uns #(.widthX(7)) u7 (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy7),
      .Q_i(q), .R_i(r), .out_valid_o(v7), .out_ready_i(out_ready),
      .X_o(x7), .ovf_o(ovf7), .inv_o(inv7));

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] x8;
      logic       ovf8;
      logic [6:0] x7;
      logic       ovf7;
      logic       inv;
   } exp_t;

   exp_t exp_q[$];
   int   acc_q[$];
   int   n_vec = 0, n_err = 0, cyc = 0;
   logic pv = 1'b0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input int qv, input int rv, input int x, input int o, input int iv);
      exp_t e;
      int   s;
      s      = qv * qv + rv;
      e.x8   = x[7:0];
      e.ovf8 = o[0];
      e.x7   = s[6:0];
      e.ovf7 = (s >= 128);
      e.inv  = iv[0];
      exp_q.push_back(e);
   endtask

   task automatic send(input int qv, input int rv, input int x, input int o, input int iv);
      int n;
      push_exp(qv, rv, x, o, iv);
      @(posedge clk); #1;
      in_valid = 1'b1; q = qv[3:0]; r = rv[4:0];
      n = 0;
      while (!rdy8 && n < 50) begin @(posedge clk); #1; n++; end
      chk("accept_wait", n < 50, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 200) begin @(posedge clk); n++; end
      #1;
      chk("drain", exp_q.size(), 0);
   endtask

   // Monitor: latency of every accepted pair, and result contents on each output handshake.
   always @(negedge clk) begin : mon
      exp_t e;
      int   a;
      if (!rst_n) pv <= 1'b0;
      else begin
         chk("lockstep_valid", v7, v8);
         if (in_valid && rdy8) acc_q.push_back(cyc + 1);
         if (v8 && !pv) begin
            if (acc_q.size() > 0) begin
               a = acc_q.pop_front();
               chk("latency", cyc - a, 4);
            end else chk("spurious_valid", acc_q.size(), 1);
         end
         if (v8 && out_ready) begin
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("x8", x8, e.x8);
               chk("ovf8", ovf8, e.ovf8);
               chk("inv8", inv8, e.inv);
               chk("x7", x7, e.x7);
               chk("ovf7", ovf7, e.ovf7);
               chk("inv7", inv7, e.inv);
            end else chk("unexpected_out", exp_q.size(), 1);
         end
         pv <= v8;
      end
   end

   initial begin
      int n, s;
      #1;
      chk("rst_ready", rdy8, 1);
      chk("rst_valid", v8, 0);
      chk("rst_x", x8, 0);
      chk("rst_ovf", ovf8, 0);
      chk("rst_inv", inv8, 0);
      chk("rst_ready7", rdy7, 1);
      @(posedge clk); #1 rst_n = 1'b1;

      send(11, 6, 127, 0, 0);
      send(15, 30, 255, 0, 0);
      send(0, 0, 0, 0, 0);
      send(0, 1, 1, 0, 1);
      send(15, 31, 0, 1, 1);
      send(3, 7, 16, 0, 1);
      drain();

      // Backpressure with a second pair waiting on the input.
      out_ready = 1'b0;
      send(9, 4, 85, 0, 0);
      n = 0;
      while (!v8 && n < 20) begin @(negedge clk); n++; end
      chk("bp_valid_wait", n < 20, 1);
      push_exp(2, 1, 5, 0, 0);
      @(posedge clk); #1;
      in_valid = 1'b1; q = 4'd2; r = 5'd1;
      repeat (6) begin
         @(negedge clk);
         chk("bp_x_hold", x8, 85);
         chk("bp_valid_hold", v8, 1);
         chk("bp_ready_low", rdy8, 0);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_idle_ready", rdy8, 1);
      chk("bp_valid_drop", v8, 0);
      @(posedge clk); #1;
      chk("bp_accepted", rdy8, 0);
      in_valid = 1'b0;
      drain();

      // Reset in the middle of CALC discards the pending result.
      send(13, 2, 171, 0, 0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", v8, 0);
      chk("mid_rst_ready", rdy8, 1);
      exp_q.delete();
      acc_q.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      send(5, 10, 35, 0, 0);
      drain();

      // Sweep every legal (Q,R) pair for both widths.
      for (int qv = 0; qv < 16; qv++)
         for (int rv = 0; rv <= 2 * qv; rv++) begin
            s = qv * qv + rv;
            send(qv, rv, s % 256, int'(s >= 256), int'(rv > 2 * qv));
         end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1, "timeout");
   end

endmodule
